// File: rtl/word_serializer.sv
// Word-to-beat serializer: pops a DATA_WIDTH word and emits N OUT_WIDTH beats, first beat one cycle after the pop.
// Beats hold stable under out_ready_i=0; the next word is popped on the last beat's acceptance so words stream without bubbles.
module word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int N     = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((DATA_WIDTH % OUT_WIDTH) != 0 || N < 2) begin : g_bad_ratio
    $error("word_serializer: DATA_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  data_q, data_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic             accept;
  logic             load;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [OUT_WIDTH-1:0] pick(input logic [DATA_WIDTH-1:0] w,
                                                input logic [CNT_W-1:0] c);
    int idx;
    idx = MSB_FIRST ? (N - 1 - int'(c)) : int'(c);
    return w[idx*OUT_WIDTH +: OUT_WIDTH];
  endfunction

  always_comb begin
    accept     = (state_q == SHIFT) && out_ready_i;
    load       = !flush_i && !fifo_empty_i &&
                 ((state_q == IDLE) || (accept && (cnt_q == LAST_CNT)));
    fifo_pop_o = rst_ni && load;
    cnt_nxt    = cnt_q + CNT_W'(1);

    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    busy_d  = busy_q;

    // Flush wins over everything, including a same-cycle last-beat acceptance.
    if (flush_i || (accept && (cnt_q == LAST_CNT) && !load)) begin
      state_d = IDLE;
      cnt_d   = '0;
      data_d  = '0;
      last_d  = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else if (load) begin
      state_d = SHIFT;
      word_d  = fifo_data_i;
      cnt_d   = '0;
      data_d  = pick(fifo_data_i, '0);
      last_d  = 1'b0;
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end else if (accept) begin
      cnt_d  = cnt_nxt;
      data_d = pick(word_q, cnt_nxt);
      last_d = (cnt_nxt == LAST_CNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each word read from the upstream FIFO.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, width of each output beat; DATA_WIDTH SHALL be an integer multiple of OUT_WIDTH, with ratio N = DATA_WIDTH/OUT_WIDTH >= 2.
REQ-003 SHALL have parameter MSB_FIRST, default 1'b1; 1 emits the most-significant slice first, 0 emits the least-significant slice first.
REQ-004 SHALL have one clock; reset is synchronous and active-low (clk_i, rst_ni).
REQ-005 clk_i  input  1  clock; all state changes on the rising edge.
REQ-006 rst_ni  input  1  synchronous active-low reset.
REQ-007 flush_i  input  1  synchronous abort; drops the word in progress.
REQ-008 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-009 fifo_data_i  input  DATA_WIDTH  upstream FIFO head word; valid whenever fifo_empty_i=0.
REQ-010 fifo_pop_o  output  1  pops the FIFO head; combinational, at most one per cycle.
REQ-011 out_data_o  output  OUT_WIDTH  current beat.
REQ-012 out_valid_o  output  1  beat valid.
REQ-013 out_ready_i  input  1  downstream accepts the beat.
REQ-014 out_last_o  output  1  current beat is the final slice of its word.
REQ-015 busy_o  output  1  a word is loaded and not yet fully emitted.

Function
REQ-016 SHALL implement FSM states IDLE and SHIFT, with a word register of DATA_WIDTH bits and a slice counter of $clog2(N) bits.
REQ-017 In IDLE, SHALL set out_valid_o=0 and busy_o=0.
REQ-018 In IDLE with fifo_empty_i=0 and flush_i=0, SHALL assert fifo_pop_o in that cycle, capture fifo_data_i, clear the counter, and enter SHIFT on the next edge.
REQ-019 In SHIFT, SHALL drive out_valid_o=1 and busy_o=1.
REQ-020 In SHIFT, out_data_o SHALL be slice N-1-cnt when MSB_FIRST=1, else slice cnt.
REQ-021 out_data_o, out_data_o's word, and out_last_o SHALL be driven from registers only; out_last_o = (cnt == N-1) in SHIFT, else 0.
REQ-022 A beat is accepted when out_valid_o=1 and out_ready_i=1; while out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o SHALL hold stable.
REQ-023 On acceptance with cnt < N-1, SHALL increment cnt by 1 and stay in SHIFT.
REQ-024 On acceptance with cnt == N-1 and fifo_empty_i=0, SHALL assert fifo_pop_o in the same cycle, load fifo_data_i, clear cnt, and stay in SHIFT (zero-bubble back-to-back words).
REQ-025 On acceptance with cnt == N-1 and fifo_empty_i=1, SHALL return to IDLE.
REQ-026 fifo_pop_o SHALL never be asserted while fifo_empty_i=1, while flush_i=1, or in SHIFT unless the last beat is accepted that cycle.
REQ-027 Sustained throughput SHALL be one beat per cycle when out_ready_i=1 and the FIFO stays non-empty; the first beat of a word SHALL appear one cycle after its pop.
REQ-028 flush_i=1 SHALL force IDLE and cnt=0 on the next edge, regardless of out_ready_i; an acceptance in a flush cycle is still counted downstream but SHALL NOT trigger a pop.

Reset
REQ-029 With rst_ni=0 at a rising edge, SHALL enter IDLE and clear the counter and word register to 0.
REQ-030 During and after reset, until the first pop, out_valid_o, out_last_o, busy_o and out_data_o SHALL be 0.
REQ-031 fifo_pop_o SHALL be 0 in every cycle where rst_ni=0.
REQ-032 Reset mid-word SHALL discard the remaining slices; no partial word is resumed.

Verification
REQ-033 Defaults (32/8/MSB_FIRST=1), FIFO holds 0xA1B2C3D4, out_ready_i=1: pop once; beats A1,B2,C3,D4 on 4 consecutive cycles; out_last_o only on D4; then IDLE.
REQ-034 Words 0x11223344 and 0x55667788 queued, out_ready_i=1: 8 beats on consecutive cycles with no bubble; second pop coincides with acceptance of 0x44; out_last_o on 0x44 and 0x88.
REQ-035 Backpressure, word 0xA1B2C3D4: out_ready_i=0 for 3 cycles while B2 is presented; B2 and out_valid_o hold for those 3 cycles; no pop occurs; sequence then completes unchanged.
REQ-036 MSB_FIRST=0, word 0xA1B2C3D4: beats D4,C3,B2,A1.
REQ-037 flush_i pulsed while C3 is presented: next cycle is IDLE with out_valid_o=0; the next queued word 0xCAFEF00D is popped afterward and emits CA,FE,F0,0D.
REQ-038 rst_ni=0 for 1 cycle while B2 is presented, FIFO empty after: all outputs are 0, and no pop occurs until new data arrives.
